// File: rtl/booth_divider_withregs_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_divider_withregs_if : request/result bundle for the Booth divider  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface booth_divider_withregs_if #(
   parameter int N = 32
);
   logic         en;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   modport master (
      output en, start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  en, start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/booth_divider_withregs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_divider_withregs : iterative radix-2 non-restoring divider, N+1    |
// | clocks per operation. DIV_SIGNED_EN selects signed, otherwise unsigned.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module booth_divider_withregs #(
   parameter int N = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   booth_divider_withregs_if.slave  bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [N:0]     pr_q, pr_d;
   logic [N-1:0]   q_q, q_d;
   logic [N-1:0]   dvs_q, dvs_d;
   logic           neg_quo_q, neg_quo_d;
   logic           neg_rem_q, neg_rem_d;
   logic           dbz_q, dbz_d;
   logic [N-1:0]   quotient_q, quotient_d;
   logic [N-1:0]   remainder_q, remainder_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           div_by_zero_q, div_by_zero_d;

   logic [N:0]     pr_shift;
   logic [N:0]     pr_step;
   logic [N:0]     pr_fix;
   logic [N-1:0]   dividend_mag;
   logic [N-1:0]   divisor_mag;
   logic           dividend_neg;
   logic           divisor_neg;

   always_comb begin
`ifdef DIV_SIGNED_EN
      dividend_neg = bus.dividend[N-1];
      divisor_neg  = bus.divisor[N-1];
`else
      dividend_neg = 1'b0;
      divisor_neg  = 1'b0;
`endif
      dividend_mag = dividend_neg ? (~bus.dividend + 1'b1) : bus.dividend;
      divisor_mag  = divisor_neg  ? (~bus.divisor  + 1'b1) : bus.divisor;

      // Sign of the partial remainder before the shift picks add or subtract
      pr_shift = {pr_q[N-1:0], q_q[N-1]};
      pr_step  = pr_q[N] ? (pr_shift + {1'b0, dvs_q}) : (pr_shift - {1'b0, dvs_q});
      pr_fix   = pr_q[N] ? (pr_q + {1'b0, dvs_q}) : pr_q;

      state_d       = state_q;
      count_d       = count_q;
      pr_d          = pr_q;
      q_d           = q_q;
      dvs_d         = dvs_q;
      neg_quo_d     = neg_quo_q;
      neg_rem_d     = neg_rem_q;
      dbz_d         = dbz_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      busy_d        = busy_q;
      done_d        = done_q;
      div_by_zero_d = div_by_zero_q;

      if (bus.en) begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  busy_d    = 1'b1;
                  pr_d      = '0;
                  dvs_d     = divisor_mag;
                  neg_quo_d = dividend_neg ^ divisor_neg;
                  neg_rem_d = dividend_neg;
                  if (bus.divisor == '0) begin
                     // Raw dividend parks in the quotient register to become the remainder
                     dbz_d   = 1'b1;
                     q_d     = bus.dividend;
                     state_d = S_FIX;
                  end else begin
                     dbz_d   = 1'b0;
                     q_d     = dividend_mag;
                     count_d = CW'(N - 1);
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               pr_d = pr_step;
               q_d  = {q_q[N-2:0], ~pr_step[N]};
               if (count_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  count_d = count_q - CW'(1);
               end
            end
            S_FIX: begin
               if (dbz_q) begin
                  quotient_d  = '1;
                  remainder_d = q_q;
               end else begin
                  quotient_d  = neg_quo_q ? (~q_q + 1'b1) : q_q;
                  remainder_d = neg_rem_q ? (~pr_fix[N-1:0] + 1'b1) : pr_fix[N-1:0];
               end
               div_by_zero_d = dbz_q;
               done_d        = 1'b1;
               busy_d        = 1'b0;
               state_d       = S_DONE;
            end
            S_DONE: begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         count_q       <= '0;
         pr_q          <= '0;
         q_q           <= '0;
         dvs_q         <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         dbz_q         <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         pr_q          <= pr_d;
         q_q           <= q_d;
         dvs_q         <= dvs_d;
         neg_quo_q     <= neg_quo_d;
         neg_rem_q     <= neg_rem_d;
         dbz_q         <= dbz_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = div_by_zero_q;
endmodule
`default_nettype wire

// File: tb/tb_booth_divider_withregs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_booth_divider_withregs : directed bench for booth_divider_withregs    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_booth_divider_withregs;
   localparam int N = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   bit   done_seen = 1'b0;

   booth_divider_withregs_if #(.N(N)) bus ();

   booth_divider_withregs #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_done(input string tag, input int elapsed, input int exp_cycles);
      int cyc = elapsed;
      bit seen = 1'b0;
      while (!seen && cyc < 200) begin
         tick();
         cyc++;
         if (bus.done) seen = 1'b1;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(exp_cycles));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en       = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      reset        = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      check("rst_quotient",  64'(bus.quotient),    64'd0);
      check("rst_remainder", 64'(bus.remainder),   64'd0);
      check("rst_busy",      64'(bus.busy),        64'd0);
      check("rst_done",      64'(bus.done),        64'd0);
      check("rst_dbz",       64'(bus.div_by_zero), 64'd0);

      // 100 / 7
      start_op("u100_7", 32'd100, 32'd7);
      wait_done("u100_7", 0, N + 1);
      check("u100_7_q",    64'(bus.quotient),    64'd14);
      check("u100_7_r",    64'(bus.remainder),   64'd2);
      check("u100_7_busy", 64'(bus.busy),        64'd0);
      check("u100_7_dbz",  64'(bus.div_by_zero), 64'd0);
      tick();
      check("u100_7_pulse", 64'(bus.done),     64'd0);
      check("u100_7_hold",  64'(bus.quotient), 64'd14);

      // -100 / 7
      start_op("n100_7", 32'hFFFF_FF9C, 32'd7);
      wait_done("n100_7", 0, N + 1);
`ifdef DIV_SIGNED_EN
      check("n100_7_q", 64'(bus.quotient),  64'h0000_0000_FFFF_FFF2);
      check("n100_7_r", 64'(bus.remainder), 64'h0000_0000_FFFF_FFFE);
`else
      check("n100_7_q", 64'(bus.quotient),  64'h0000_0000_2492_4916);
      check("n100_7_r", 64'(bus.remainder), 64'd2);
`endif
      tick();

      // Divide by zero
      start_op("dbz5", 32'd5, 32'd0);
      wait_done("dbz5", 0, 1);
      check("dbz5_q",    64'(bus.quotient),    64'h0000_0000_FFFF_FFFF);
      check("dbz5_r",    64'(bus.remainder),   64'd5);
      check("dbz5_flag", 64'(bus.div_by_zero), 64'd1);
      tick();
      check("dbz5_flag_hold", 64'(bus.div_by_zero), 64'd1);

      start_op("dbzn5", 32'hFFFF_FFFB, 32'd0);
      wait_done("dbzn5", 0, 1);
      check("dbzn5_q", 64'(bus.quotient),  64'h0000_0000_FFFF_FFFF);
      check("dbzn5_r", 64'(bus.remainder), 64'h0000_0000_FFFF_FFFB);
      tick();

      // Most negative / -1
      start_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("ovf", 0, N + 1);
`ifdef DIV_SIGNED_EN
      check("ovf_q", 64'(bus.quotient),  64'h0000_0000_8000_0000);
      check("ovf_r", 64'(bus.remainder), 64'd0);
`else
      check("ovf_q", 64'(bus.quotient),  64'd0);
      check("ovf_r", 64'(bus.remainder), 64'h0000_0000_8000_0000);
`endif
      check("ovf_dbz", 64'(bus.div_by_zero), 64'd0);
      tick();

      // Abort: second start ignored, reset mid-CALC, no done pulse
      done_seen = 1'b0;
      start_op("abort", 32'd1000, 32'd10);
      repeat (9) tick();
      bus.dividend = 32'd9;
      bus.divisor  = 32'd3;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      repeat (9) tick();
      check("abort_busy_mid", 64'(bus.busy), 64'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_busy",      64'(bus.busy),      64'd0);
      check("abort_quotient",  64'(bus.quotient),  64'd0);
      check("abort_remainder", 64'(bus.remainder), 64'd0);
      repeat (40) tick();
      check("abort_no_done", 64'(done_seen), 64'd0);

      start_op("r9_3", 32'd9, 32'd3);
      wait_done("r9_3", 0, N + 1);
      check("r9_3_q", 64'(bus.quotient),  64'd3);
      check("r9_3_r", 64'(bus.remainder), 64'd0);
      tick();

      // Clock-enable stall mid-CALC
      start_op("en77_5", 32'd77, 32'd5);
      repeat (4) tick();
      bus.en = 1'b0;
      repeat (8) tick();
      check("en77_5_busy_stall", 64'(bus.busy), 64'd1);
      bus.en = 1'b1;
      wait_done("en77_5", 12, N + 1 + 8);
      check("en77_5_q", 64'(bus.quotient),  64'd15);
      check("en77_5_r", 64'(bus.remainder), 64'd2);
      bus.en = 1'b0;
      repeat (3) tick();
      check("en77_5_done_held", 64'(bus.done), 64'd1);
      bus.en       = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      check("done_start_ignored_done", 64'(bus.done), 64'd0);
      check("done_start_ignored_busy", 64'(bus.busy), 64'd0);
      repeat (2) tick();
      check("done_start_ignored_q", 64'(bus.quotient), 64'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
